sram_bank_ctrl: RTL

Parametrised request/response front-end for `NUM_BANKS` single-port SRAM macros (active-low `CEN`/`WEN`, `EMA`, `RETN` pins).
- Hides the macro's active-low, one-cycle-read protocol behind a valid/ready interface.
- Adds address interleaving across banks, byte-enable writes via read-modify-write, a backpressured response queue and a retention (sleep) mode.
- Sits between the vector register-file / storage logic and the SRAM macro instances.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_rsp_fifo.sv | 46 ++++
 rtl/sram_bank_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM bank controller: FSM state encoding,
// default macro margin setting and the address-to-bank mapping.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RMW_WR,
      ST_RET_DRAIN,
      ST_RETENTION,
      ST_WAKE
   } sram_ctrl_state_e;

   localparam logic [2:0] EMA_DEFAULT = 3'b000;

   // Banks are interleaved on the low word-address bits; num_banks is a power of two.
   function automatic int unsigned bank_idx(input logic [31:0] addr, input int unsigned num_banks);
      return addr & (num_banks - 1);
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry synchronous FIFO holding read responses until the consumer takes them.
// Head reads as zero while empty.
module sram_rsp_fifo #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   // NOTE: the data storage is deliberately not reset; the count gates
   // visibility, so stale contents can never reach the head output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_bank_ctrl.sv
// Valid/ready front-end for NUM_BANKS single-port SRAM macros: bank interleaving,
// byte-enable writes by read-modify-write, a 2-entry response queue and retention.
module sram_bank_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter  int         DATA_W    = 32,
   parameter  int         ADDR_W    = 11,
   parameter  int         NUM_BANKS = 2,
   parameter  logic [2:0] EMA_VAL   = EMA_DEFAULT,
   localparam int         SEL_W     = $clog2(NUM_BANKS),
   localparam int         REQ_AW    = ADDR_W + SEL_W,
   localparam int         BE_W      = DATA_W / 8,
   localparam int         BANK_W    = (NUM_BANKS > 1) ? SEL_W : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_we,
   input  logic [REQ_AW-1:0]             req_addr,
   input  logic [DATA_W-1:0]             req_wdata,
   input  logic [BE_W-1:0]               req_be,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_W-1:0]             rsp_rdata,
   input  logic                          ret_req,
   output logic                          ret_ack,
   output logic [NUM_BANKS-1:0]          sram_cen,
   output logic [NUM_BANKS-1:0]          sram_wen,
   output logic [NUM_BANKS*ADDR_W-1:0]   sram_a,
   output logic [NUM_BANKS*DATA_W-1:0]   sram_d,
   input  logic [NUM_BANKS*DATA_W-1:0]   sram_q,
   output logic [2:0]                    sram_ema,
   output logic                          sram_retn
);

   sram_ctrl_state_e  state, state_nxt;

   logic [BANK_W-1:0] req_bank;
   logic [ADDR_W-1:0] req_macro_addr;
   logic              accept;
   logic              is_read;
   logic              is_full_wr;
   logic              is_part_wr;
   logic              room;

   logic              rd_pend;
   logic [BANK_W-1:0] rd_bank;
   logic [BANK_W-1:0] rmw_bank;
   logic [ADDR_W-1:0] rmw_addr;
   logic [DATA_W-1:0] rmw_wdata;
   logic [BE_W-1:0]   rmw_be;
   logic [DATA_W-1:0] rmw_q;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] rd_q;

   logic [1:0]        fifo_count;
   logic              fifo_pop;

   assign req_bank       = BANK_W'(bank_idx(32'(req_addr), NUM_BANKS));
   assign req_macro_addr = req_addr[REQ_AW-1 -: ADDR_W];

   assign is_read    = !req_we;
   assign is_full_wr = req_we && (&req_be);
   assign is_part_wr = req_we && (|req_be) && !(&req_be);

   assign rsp_valid = (fifo_count != 2'd0);
   assign fifo_pop  = rsp_valid && rsp_ready;

   // A slot freed by this cycle's pop may be reused, which keeps reads at one per cycle.
   assign room = ({1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, fifo_pop}) < 3'd2;

   assign req_ready = rst && (state == ST_IDLE) && !ret_req && (req_we || room);
   assign accept    = req_valid && req_ready;

   assign rd_q  = sram_q[DATA_W*rd_bank +: DATA_W];
   assign rmw_q = sram_q[DATA_W*rmw_bank +: DATA_W];

   always_comb begin
      merged = rmw_q;
      for (int i = 0; i < BE_W; i++) begin
         if (rmw_be[i]) merged[8*i +: 8] = rmw_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         rd_pend   <= 1'b0;
         rd_bank   <= '0;
         rmw_bank  <= '0;
         rmw_addr  <= '0;
         rmw_wdata <= '0;
         rmw_be    <= '0;
      end else begin
         state   <= state_nxt;
         rd_pend <= accept && is_read;
         if (accept) rd_bank <= req_bank;
         if (accept && is_part_wr) begin
            rmw_bank  <= req_bank;
            rmw_addr  <= req_macro_addr;
            rmw_wdata <= req_wdata;
            rmw_be    <= req_be;
         end
      end
   end

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (ret_req)                  state_nxt = ST_RET_DRAIN;
            else if (accept && is_part_wr) state_nxt = ST_RMW_WR;
         end
         ST_RMW_WR:    state_nxt = ret_req ? ST_RET_DRAIN : ST_IDLE;
         ST_RET_DRAIN: if (!rd_pend && (fifo_count == 2'd0)) state_nxt = ST_RETENTION;
         ST_RETENTION: if (!ret_req) state_nxt = ST_WAKE;
         ST_WAKE:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Macro pins follow the accepted request directly so the macro samples at the acceptance edge.
   always_comb begin
      sram_cen = '1;
      sram_wen = '1;
      sram_a   = '0;
      sram_d   = '0;
      if (rst) begin
         if (state == ST_RMW_WR) begin
            sram_cen[rmw_bank]                  = 1'b0;
            sram_wen[rmw_bank]                  = 1'b0;
            sram_a[ADDR_W*rmw_bank +: ADDR_W]   = rmw_addr;
            sram_d[DATA_W*rmw_bank +: DATA_W]   = merged;
         end else if (accept && (is_read || (req_be != '0))) begin
            sram_cen[req_bank]                  = 1'b0;
            sram_wen[req_bank]                  = !is_full_wr;
            sram_a[ADDR_W*req_bank +: ADDR_W]   = req_macro_addr;
            if (is_full_wr) sram_d[DATA_W*req_bank +: DATA_W] = req_wdata;
         end
      end
   end

   assign sram_ema  = EMA_VAL;
   assign sram_retn = !(rst && (state == ST_RETENTION));
   assign ret_ack   = (state == ST_RETENTION);

   sram_rsp_fifo #(
      .DATA_W (DATA_W)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend),
      .push_data (rd_q),
      .pop       (fifo_pop),
      .head      (rsp_rdata),
      .count     (fifo_count)
   );

endmodule
